// File: rtl/ifu_fetch_pkg.sv
// Shared encodings and defaults for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          IM_WORDS_DEFAULT = 4096;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_op_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC selection and fetch-range validity check.
module npc_calc
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4,
    output logic        npc_valid
);

    localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * (IM_WORDS - 1));

    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (npc_op_e'(npc_op))
            NPC_SEQ: npc = pc_plus4;
            NPC_BR:  npc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            NPC_J:   npc = {pc_plus4[31:28], imm26, 2'b00};
            NPC_JR:  npc = rs_data;
            default: npc = pc_plus4;
        endcase
    end

    // Unsigned bounds: a wrapped target such as 32'hFFFF_FFFC lands above PC_LAST.
    assign npc_valid = (npc[1:0] == 2'b00) && (npc >= PC_RESET) && (npc <= PC_LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: PC register, run/error FSM and retired-update counter.
// state | meaning
// RUN   | fetching; PC advances on every unstalled valid next-PC
// ERR   | sticky fault after an invalid target; only reset leaves
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    input  logic [31:0] im_instr,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        fetch_err,
    output logic [31:0] retired
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] npc;
    logic        npc_valid;

    npc_calc #(
        .PC_RESET (PC_RESET),
        .IM_WORDS (IM_WORDS)
    ) u_npc_calc (
        .pc        (pc_q),
        .npc_op    (npc_op),
        .br_taken  (br_taken),
        .imm16     (imm16),
        .imm26     (imm26),
        .rs_data   (rs_data),
        .npc       (npc),
        .pc_plus4  (pc_plus4),
        .npc_valid (npc_valid)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (npc_valid) begin
                        pc_d      = npc;
                        retired_d = retired_q + 32'd1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= PC_RESET;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign pc        = pc_q;
    assign retired   = retired_q;
    assign fetch_err = (state_q == ST_ERR);
    assign instr     = (state_q == ST_RUN) ? im_instr : 32'h0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboarded bench for ifu_fetch: full-size instance plus a 4-word instance for bound tests.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken;
    logic [1:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;

    logic [31:0] pc_a, instr_a, p4_a, ret_a, im_a;
    logic        err_a;
    logic [31:0] pc_b, instr_b, p4_b, ret_b, im_b;
    logic        err_b;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_pc[2];
    logic [31:0] m_ret[2];
    logic        m_err[2];

    always #5 clk = ~clk;

    assign im_a = {pc_a[15:0], ~pc_a[15:0]};
    assign im_b = {pc_b[15:0], ~pc_b[15:0]};

    ifu_fetch dut_a (
        .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_taken(br_taken),
        .imm16(imm16), .imm26(imm26), .rs_data(rs_data), .pc(pc_a), .im_instr(im_a),
        .instr(instr_a), .pc_plus4(p4_a), .fetch_err(err_a), .retired(ret_a)
    );

    ifu_fetch #(.PC_RESET(32'h0000_3000), .IM_WORDS(4)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .br_taken(br_taken),
        .imm16(imm16), .imm26(imm26), .rs_data(rs_data), .pc(pc_b), .im_instr(im_b),
        .instr(instr_b), .pc_plus4(p4_b), .fetch_err(err_b), .retired(ret_b)
    );

    function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [1:0] op,
                                            input logic br, input logic [15:0] i16,
                                            input logic [25:0] i26, input logic [31:0] rs);
        logic [31:0] p4;
        p4 = p + 32'd4;
        case (op)
            2'd0:    return p4;
            2'd1:    return br ? p4 + {{14{i16[15]}}, i16, 2'b00} : p4;
            2'd2:    return {p4[31:28], i26, 2'b00};
            default: return rs;
        endcase
    endfunction

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic step(input logic rst, input logic st, input logic [1:0] op, input logic br,
                        input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
        exp_t e[2];
        logic [31:0] n, last;
        reset = rst; stall = st; npc_op = op; br_taken = br;
        imm16 = i16; imm26 = i26; rs_data = rs;
        for (int k = 0; k < 2; k++) begin
            last = (k == 0) ? 32'h0000_3000 + 32'd4 * 32'd4095 : 32'h0000_300C;
            if (rst) begin
                m_pc[k] = 32'h0000_3000; m_ret[k] = 32'd0; m_err[k] = 1'b0;
            end else if (!m_err[k] && !st) begin
                n = ref_npc(m_pc[k], op, br, i16, i26, rs);
                if (n[1:0] == 2'b00 && n >= 32'h0000_3000 && n <= last) begin
                    m_pc[k] = n; m_ret[k] = m_ret[k] + 32'd1;
                end else begin
                    m_err[k] = 1'b1;
                end
            end
            e[k].pc = m_pc[k]; e[k].ret = m_ret[k]; e[k].err = m_err[k];
            sbq.push_back(e[k]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_t x;
            logic [31:0] o_pc, o_ret, o_ins, o_p4, x_ins;
            logic        o_err;
            x = sbq.pop_front();
            o_pc  = (k == 0) ? pc_a : pc_b;
            o_ret = (k == 0) ? ret_a : ret_b;
            o_err = (k == 0) ? err_a : err_b;
            o_ins = (k == 0) ? instr_a : instr_b;
            o_p4  = (k == 0) ? p4_a : p4_b;
            x_ins = x.err ? 32'h0 : {x.pc[15:0], ~x.pc[15:0]};
            n_total++;
            if (o_pc !== x.pc || o_ret !== x.ret || o_err !== x.err ||
                o_ins !== x_ins || o_p4 !== x.pc + 32'd4)
                $display("FAIL sb dut%0d t=%0t: pc=%h ret=%0d err=%b instr=%h p4=%h, want pc=%h ret=%0d err=%b instr=%h p4=%h",
                         k, $time, o_pc, o_ret, o_err, o_ins, o_p4,
                         x.pc, x.ret, x.err, x_ins, x.pc + 32'd4);
            else
                n_pass++;
        end
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        n_total++;
        if (pc_a !== 32'h3000 || ret_a !== 32'd0 || err_a !== 1'b0)
            $display("FAIL reset: pc=%h ret=%0d err=%b, want 3000/0/0", pc_a, ret_a, err_a);
        else n_pass++;
    endtask

    task automatic test_seq();
        seq(3);
        n_total++;
        if (pc_a !== 32'h300C || ret_a !== 32'd3 || instr_a !== 32'h300C_CFF3)
            $display("FAIL seq: pc=%h ret=%0d instr=%h, want 300c/3/300ccff3", pc_a, ret_a, instr_a);
        else n_pass++;
    endtask

    task automatic test_branch();
        seq(1);
        step(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        n_total++;
        if (pc_a !== 32'h3004) $display("FAIL br_taken: pc=%h, want 3004", pc_a);
        else n_pass++;
        seq(3);
        step(1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        n_total++;
        if (pc_a !== 32'h3014) $display("FAIL br_not_taken: pc=%h, want 3014", pc_a);
        else n_pass++;
    endtask

    task automatic test_jump();
        seq(3);
        step(1'b0, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0);
        n_total++;
        if (pc_a !== 32'h3040) $display("FAIL j: pc=%h, want 3040", pc_a);
        else n_pass++;
        step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3100);
        n_total++;
        if (pc_a !== 32'h3100) $display("FAIL jr: pc=%h, want 3100", pc_a);
        else n_pass++;
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        seq(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0);
        n_total++;
        if (pc_a !== 32'h3008 || ret_a !== 32'd2 || err_a !== 1'b0)
            $display("FAIL stall: pc=%h ret=%0d err=%b, want 3008/2/0", pc_a, ret_a, err_a);
        else n_pass++;
    endtask

    task automatic test_self_loop();
        step(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFF, 26'h0, 32'h0);
        n_total++;
        if (pc_a !== 32'h3008 || ret_a !== 32'd3)
            $display("FAIL self_loop: pc=%h ret=%0d, want 3008/3", pc_a, ret_a);
        else n_pass++;
    endtask

    task automatic test_invalid();
        step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h3002);
        n_total++;
        if (err_a !== 1'b1 || pc_a !== 32'h3008 || instr_a !== 32'h0)
            $display("FAIL misaligned: err=%b pc=%h instr=%h, want 1/3008/0", err_a, pc_a, instr_a);
        else n_pass++;
        seq(2);
        n_total++;
        if (pc_a !== 32'h3008 || ret_a !== 32'd3 || err_a !== 1'b1)
            $display("FAIL err_frozen: pc=%h ret=%0d err=%b, want 3008/3/1", pc_a, ret_a, err_a);
        else n_pass++;
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        n_total++;
        if (pc_a !== 32'h3000 || err_a !== 1'b0)
            $display("FAIL err_reset: pc=%h err=%b, want 3000/0", pc_a, err_a);
        else n_pass++;
        step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        n_total++;
        if (err_a !== 1'b1 || pc_a !== 32'h3000)
            $display("FAIL jr_wrap: err=%b pc=%h, want 1/3000", err_a, pc_a);
        else n_pass++;
    endtask

    task automatic test_upper_bound();
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        seq(3);
        n_total++;
        if (pc_b !== 32'h300C || err_b !== 1'b0)
            $display("FAIL last_word: pc=%h err=%b, want 300c/0", pc_b, err_b);
        else n_pass++;
        seq(1);
        n_total++;
        if (err_b !== 1'b1 || pc_b !== 32'h300C || instr_b !== 32'h0 || pc_a !== 32'h3010)
            $display("FAIL past_end: err=%b pc=%h instr=%h big_pc=%h, want 1/300c/0/3010",
                     err_b, pc_b, instr_b, pc_a);
        else n_pass++;
        step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step(1'b1, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        n_total++;
        if (pc_b !== 32'h3000 || err_b !== 1'b0 || pc_a !== 32'h3000)
            $display("FAIL reset_in_stall: pc_b=%h err_b=%b pc_a=%h, want 3000/0/3000", pc_b, err_b, pc_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 3)), 26'h0000C00 + 26'($urandom_range(0, 15)), 32'h0);
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    initial begin
        m_pc[0] = 32'h0; m_pc[1] = 32'h0; m_ret[0] = 32'h0; m_ret[1] = 32'h0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_stall();
        test_self_loop();
        test_invalid();
        test_upper_bound();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the single-cycle MIPS core. It is the initiator on the PC→instruction interface.
- Holds the architectural PC and drives it to the instruction memory.
- Receives the combinational instruction word and presents it to decode.
- Computes next-PC for sequential, branch, jump and jump-register flow; traps out-of-range/misaligned fetches into a sticky error state.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset (text segment base).
- IM_WORDS, 4096, instruction memory depth in words; valid fetch range is PC_RESET .. PC_RESET+4*IM_WORDS-4.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC (no update) this cycle
- npc_op  input  2  next-PC select: 0 SEQ, 1 BR, 2 J, 3 JR
- br_taken  input  1  branch condition result from ALU/compare (used only when npc_op=BR)
- imm16  input  16  branch offset from current instruction
- imm26  input  26  jump target field from current instruction
- rs_data  input  32  register value for JR
- pc  output  32  current PC, driven to instruction memory address input
- im_instr  input  32  instruction word returned by instruction memory for pc
- instr  output  32  instruction to decode
- pc_plus4  output  32  pc+4, used as link value
- fetch_err  output  1  sticky fault flag
- retired  output  32  count of committed PC updates

Behaviour:
- Reset (clk edge with reset=1):
  - pc=PC_RESET, retired=0, fetch_err=0, state=RUN.
  - Reset has priority over stall and all other inputs, including in ERR.
- Combinational outputs:
  - pc_plus4 = pc+4, modulo 2^32.
  - instr = im_instr in RUN; instr = 32'h0 (nop) in ERR.
- Next-PC computation, 32-bit wraparound arithmetic:
  - SEQ: pc+4.
  - BR: br_taken ? pc+4+(sign_extend(imm16)<<2) : pc+4.
  - J: {pc_plus4[31:28], imm26, 2'b00}.
  - JR: rs_data.
- Validity check: npc is valid iff npc[1:0]==0 and PC_RESET <= npc <= PC_RESET+4*(IM_WORDS-1), unsigned compare.
- State RUN, each edge without reset:
  - stall=1: pc, retired and state all held; inputs ignored.
  - stall=0 and npc valid: pc<=npc, retired<=retired+1 (wraps at 2^32).
  - stall=0 and npc invalid: pc held, retired held, fetch_err<=1, state<=ERR.
- State ERR: pc, retired and fetch_err frozen; only reset exits.
- Latency:
  - PC update is visible one cycle after the edge.
  - instr is combinational from pc; no fetch bubble.
- Simultaneous events:
  - reset with stall: reset wins.
  - stall with invalid npc: stall wins, no error raised.
  - Branch to self (imm16=16'hFFFF, taken): valid loop, pc unchanged, retired increments.
- Wraparound: JR to 32'hFFFF_FFFC is out of range → ERR. It is not a wrap back to the base.

Decomposition:
- Shared package/header:
  - npc_op encodings NPC_SEQ/NPC_BR/NPC_J/NPC_JR.
  - PC_RESET default.
  - FSM state encodings RUN/ERR.
- Sub-module npc_calc (purely combinational next-PC and validity logic).
- ifu_fetch keeps the PC register, FSM and counter.

Test Plan:
- Reset then 3 unstalled SEQ cycles → pc = 3000,3004,3008,300C; retired=3; instr mirrors im_instr.
- At pc=3010: BR, br_taken=1, imm16=16'hFFFC → pc=3004. Same stimulus with br_taken=0 → pc=3014.
- At pc=3020: J, imm26=26'h0000C10 → pc=3040. JR, rs_data=32'h3100 → pc=3100.
- stall=1 for 4 cycles at pc=3008 with JR to 32'h0 → pc stays 3008, retired unchanged, fetch_err=0.
- Invalid targets:
  - JR rs_data=32'h3002 (misaligned) → next edge fetch_err=1, pc stays at prior value, instr=0.
  - Subsequent SEQ cycles: no change.
  - Assert reset → pc=3000, fetch_err=0.
- Upper bound, IM_WORDS=4:
  - SEQ from 300C → ERR.
  - From 3008 → 300C, valid.
  - Reset asserted mid-stall → pc=3000 on that edge.
